// File: rtl/flash_cal_sequencer_if.sv
// rtl/flash_cal_sequencer_if.sv - calibration request, comparator, DAC and trim-result signal bundle
//
// Purpose: groups everything between the comparator-offset calibration
// sequencer and its surroundings: the start request, the comparator bank, the
// offset DAC and the trim-result store.
// Ports (signals):
//   start     one-cycle request to begin a calibration pass
//   cmp_mask  per-comparator enable, latched on an accepted start
//   q         comparator outputs, synchronous to clk
//   dac_ctl   offset DAC control word
//   cmp_sel   index of the comparator under calibration
//   res_we    trim-store write strobe; res_addr / res_data / res_sat qualify it
//   busy      pass in progress
//   done      one-cycle end-of-pass pulse
//   sat_cnt   saturated results in the last pass
// Modports: master = request/comparator side, slave = sequencer.
interface flash_cal_sequencer_if #(
    parameter int N_CMP    = 32,
    parameter int DAC_BITS = 16,
    parameter int SEL_W    = 5
);
    logic                start;
    logic [N_CMP-1:0]    cmp_mask;
    logic [N_CMP-1:0]    q;
    logic [DAC_BITS-1:0] dac_ctl;
    logic [SEL_W-1:0]    cmp_sel;
    logic                res_we;
    logic [SEL_W-1:0]    res_addr;
    logic [DAC_BITS-1:0] res_data;
    logic                res_sat;
    logic                busy;
    logic                done;
    logic [SEL_W:0]      sat_cnt;

    modport master (
        output start, cmp_mask, q,
        input  dac_ctl, cmp_sel, res_we, res_addr, res_data, res_sat, busy, done, sat_cnt
    );

    modport slave (
        input  start, cmp_mask, q,
        output dac_ctl, cmp_sel, res_we, res_addr, res_data, res_sat, busy, done, sat_cnt
    );
endinterface

// File: rtl/flash_cal_sequencer.sv
// rtl/flash_cal_sequencer.sv - successive-approximation offset-trim calibration sequencer
//
// Purpose: for every comparator enabled in the latched mask, runs an MSB-first
// successive-approximation search on the shared offset DAC and writes the
// converged code to the trim store.
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   synchronous active-high reset
//   cal_io  flash_cal_sequencer_if.slave (start, cmp_mask, q in;
//           dac_ctl, cmp_sel, res_*, busy, done, sat_cnt out)
module flash_cal_sequencer #(
    parameter int N_CMP      = 32,
    parameter int DAC_BITS   = 16,
    parameter int SETTLE_CYC = 1,
    parameter int SEL_W      = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    flash_cal_sequencer_if.slave  cal_io
);
    localparam int K_W = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;
    localparam int W_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_CLEAR, S_TRIAL, S_WAIT, S_STORE, S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [N_CMP-1:0]    mask_q, mask_d;
    logic [DAC_BITS-1:0] dac_q, dac_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [W_W-1:0]      wcnt_q, wcnt_d;
    logic [SEL_W:0]      sat_q, sat_d;
    logic                busy_q, busy_d;
    logic                last_sel;
    logic                dac_sat;
    logic                store;

    assign last_sel = (sel_q == SEL_W'(N_CMP - 1));
    assign dac_sat  = (dac_q == '0) || (&dac_q);
    assign store    = (state_q == S_STORE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            dac_q   <= '0;
            sel_q   <= '0;
            k_q     <= '0;
            wcnt_q  <= '0;
            sat_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dac_q   <= dac_d;
            sel_q   <= sel_d;
            k_q     <= k_d;
            wcnt_q  <= wcnt_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dac_d   = dac_q;
        sel_d   = sel_q;
        k_d     = k_q;
        wcnt_d  = wcnt_q;
        sat_d   = sat_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (cal_io.start) begin
                    mask_d  = cal_io.cmp_mask;
                    sel_d   = '0;
                    sat_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (mask_q[sel_q]) begin
                    state_d = S_CLEAR;
                end else if (last_sel) begin
                    state_d = S_FIN;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end
            S_CLEAR: begin
                dac_d   = '0;
                k_d     = K_W'(DAC_BITS - 1);
                state_d = S_TRIAL;
            end
            S_TRIAL: begin
                dac_d[k_q] = 1'b1;
                wcnt_d     = W_W'(SETTLE_CYC);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == W_W'(1)) begin
                    // Comparator tripped: trial code overshoots the offset, drop the bit.
                    if (cal_io.q[sel_q]) begin
                        dac_d[k_q] = 1'b0;
                    end
                    if (k_q == '0) begin
                        state_d = S_STORE;
                    end else begin
                        k_d     = k_q - 1'b1;
                        state_d = S_TRIAL;
                    end
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            S_STORE: begin
                if (dac_sat) begin
                    sat_d = sat_q + 1'b1;
                end
                if (last_sel) begin
                    state_d = S_FIN;
                end else begin
                    sel_d   = sel_q + 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                dac_d   = '0;
                sel_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cal_io.dac_ctl  = dac_q;
    assign cal_io.cmp_sel  = sel_q;
    assign cal_io.res_we   = store;
    assign cal_io.res_addr = store ? sel_q : '0;
    assign cal_io.res_data = store ? dac_q : '0;
    assign cal_io.res_sat  = store & dac_sat;
    assign cal_io.busy     = busy_q;
    assign cal_io.done     = (state_q == S_FIN);
    assign cal_io.sat_cnt  = sat_q;
endmodule

// File: tb/tb_flash_cal_sequencer.sv
// tb/tb_flash_cal_sequencer.sv - scoreboard bench for the offset-trim calibration sequencer
module tb_flash_cal_sequencer;
    localparam int N_CMP       = 32;
    localparam int DAC_BITS    = 16;
    localparam int SETTLE_CYC  = 1;
    localparam int SEL_W       = 5;
    localparam int CYC_PER_CMP = 1 + 1 + DAC_BITS * (1 + SETTLE_CYC) + 1;
    localparam int DMAX        = (1 << DAC_BITS) - 1;

    typedef struct {
        int addr;
        int data;
        bit sat;
        int rel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flash_cal_sequencer_if #(.N_CMP(N_CMP), .DAC_BITS(DAC_BITS), .SEL_W(SEL_W)) cal();

    flash_cal_sequencer #(
        .N_CMP(N_CMP), .DAC_BITS(DAC_BITS), .SETTLE_CYC(SETTLE_CYC), .SEL_W(SEL_W)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .cal_io (cal.slave)
    );

    // Comparator i trips once the DAC code reaches its threshold thr[i].
    int               thr [N_CMP];
    logic [N_CMP-1:0] qv;
    always_comb begin
        for (int i = 0; i < N_CMP; i++) qv[i] = (int'(cal.dac_ctl) >= thr[i]);
    end
    assign cal.q = qv;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus-owned pass description
    exp_t             exp_q[$];
    int               t0 = 0;
    int               exp_done_rel = 0;
    int               exp_sat = 0;
    logic [N_CMP-1:0] cur_mask = '0;
    int               pass_id = 0;
    int               abort_id = 0;
    int               rst_chk_cyc = -1;
    int               probe_cyc = -1;
    int               probe_sel = 0;
    int               probe_dac = 0;
    bit               mon_en = 1'b0;

    // Monitor-owned
    int   done_id = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rel;
    bit   active;
    exp_t e;

    // Largest code the comparator still reads as 0, clipped to the DAC range.
    function automatic int exp_code(input int t);
        if (t <= 0) return 0;
        if (t - 1 > DMAX) return DMAX;
        return t - 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            active = (pass_id != done_id) && (pass_id != abort_id);
            rel    = cyc - t0;
            if (!active) exp_q.delete();
            if (cyc == rst_chk_cyc) begin
                chk("rst_dac_ctl", cal.dac_ctl, 0);
                chk("rst_cmp_sel", cal.cmp_sel, 0);
                chk("rst_res_we", cal.res_we, 0);
                chk("rst_res_addr", cal.res_addr, 0);
                chk("rst_res_data", cal.res_data, 0);
                chk("rst_res_sat", cal.res_sat, 0);
                chk("rst_busy", cal.busy, 0);
                chk("rst_done", cal.done, 0);
                chk("rst_sat_cnt", cal.sat_cnt, 0);
            end
            if (cyc == probe_cyc) begin
                chk("probe_cmp_sel", cal.cmp_sel, probe_sel);
                chk("probe_dac_ctl", cal.dac_ctl, probe_dac);
            end
            chk("busy", cal.busy, active && (rel >= 1));
            if (!active || (cur_mask == '0)) chk("dac_idle_zero", cal.dac_ctl, 0);
            if (cal.res_we) begin
                chk("store_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("store_cycle", rel, e.rel);
                    chk("res_addr", cal.res_addr, e.addr);
                    chk("res_data", cal.res_data, e.data);
                    chk("res_sat", cal.res_sat, e.sat);
                end
            end else begin
                chk("res_idle_zero", {cal.res_addr, cal.res_data, cal.res_sat}, 0);
            end
            if (cal.done) begin
                chk("done_expected", active, 1);
                if (active) begin
                    chk("done_cycle", rel, exp_done_rel);
                    chk("sat_cnt", cal.sat_cnt, exp_sat);
                    chk("stores_left", exp_q.size(), 0);
                    done_id = pass_id;
                end
            end else if (active && (rel > exp_done_rel + 8)) begin
                chk("done_timeout", rel, exp_done_rel);
                done_id = pass_id;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [N_CMP-1:0] mask);
        int   t;
        int   ns;
        exp_t x;
        t  = 0;
        ns = 0;
        for (int i = 0; i < N_CMP; i++) begin
            if (mask[i]) begin
                t     += CYC_PER_CMP;
                x.addr = i;
                x.data = exp_code(thr[i]);
                x.sat  = (x.data == 0) || (x.data == DMAX);
                x.rel  = t;
                exp_q.push_back(x);
                if (x.sat) ns++;
            end else begin
                t += 1;
            end
        end
        exp_done_rel = t + 1;
        exp_sat      = ns;
        cur_mask     = mask;
        t0           = cyc;
        pass_id++;
        cal.cmp_mask = mask;
        cal.start    = 1'b1;
        step();
        cal.start    = 1'b0;
        cal.cmp_mask = $urandom;
    endtask

    task automatic wait_rel(input int r);
        int b;
        b = 0;
        while ((cyc - t0) < r) begin
            step();
            b++;
            if (b > 5000) begin
                $display("FAIL wait_rel bound: target %0d not reached", r);
                $fatal(1, "bench stalled");
            end
        end
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((pass_id != done_id) && (pass_id != abort_id)) begin
            step();
            b++;
            if (b > 3000) begin
                $display("FAIL wait_idle bound: pass %0d never finished", pass_id);
                $fatal(1, "bench stalled");
            end
        end
        repeat (3) step();
    endtask

    // kind 0: non-saturating codes; kind 1: full range including both rails
    task automatic rand_thr(input int kind);
        for (int i = 0; i < N_CMP; i++) begin
            if (kind == 0) thr[i] = $urandom_range(2, DMAX);
            else begin
                case ($urandom_range(0, 5))
                    0:       thr[i] = 0;
                    1:       thr[i] = DMAX + 1;
                    default: thr[i] = $urandom_range(0, DMAX + 1);
                endcase
            end
        end
    endtask

    initial begin
        cal.start    = 1'b0;
        cal.cmp_mask = '0;
        rand_thr(0);
        rst = 1'b1;
        repeat (3) step();
        rst_chk_cyc = cyc + 1;
        mon_en      = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();

        // 1: comparator 5 trips at 0x5A3C, all masked in
        rand_thr(0);
        thr[5] = 'h5A3C;
        start_pass('1);
        wait_idle();

        // 2: rails: comparator 0 always trips, comparator 31 never trips
        rand_thr(0);
        thr[0]  = 0;
        thr[31] = DMAX + 1;
        start_pass('1);
        wait_idle();

        // 3: sparse mask
        rand_thr(1);
        start_pass(32'h0000_0011);
        wait_idle();

        // 4: empty mask
        start_pass('0);
        wait_idle();

        // 5: reset during WAIT of comparator 7, bit 9, then a fresh pass
        rand_thr(1);
        start_pass('1);
        probe_cyc   = t0 + 7 * CYC_PER_CMP + 2 + (DAC_BITS - 1 - 9) * (1 + SETTLE_CYC) + 1 + SETTLE_CYC;
        probe_sel   = 7;
        probe_dac   = (exp_code(thr[7]) & 'hFC00) | 'h0200;
        rst_chk_cyc = probe_cyc + 1;
        wait_rel(probe_cyc - t0);
        rst      = 1'b1;
        abort_id = pass_id;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        rand_thr(1);
        start_pass('1);
        wait_idle();

        // 6: start pulses during the pass and in the FIN cycle are ignored
        rand_thr(1);
        start_pass('1);
        wait_rel(10);
        cal.start = 1'b1;
        step();
        cal.start = 1'b0;
        wait_rel(500);
        cal.start = 1'b1;
        step();
        cal.start = 1'b0;
        wait_rel(exp_done_rel);
        cal.start = 1'b1;
        step();
        cal.start = 1'b0;
        repeat (40) step();

        // Random masks and thresholds
        for (int n = 0; n < 2; n++) begin
            rand_thr(1);
            start_pass($urandom);
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/flash_cal_sequencer.md
Name: flash_cal_sequencer

Overview:
Synthesizable calibration controller for the flash ADC comparator bank. It runs a successive-approximation search on the shared offset-trim DAC for each selected comparator in turn. Each comparator's search ends with writing the converged DAC code to the trim-result store. It sits between the calibration start request and the comparator array, DAC and trim register file, and replaces the behavioural search loop at bring-up.

Parameters:
N_CMP, 32, number of comparators in the bank (power of 2, at most 64)
DAC_BITS, 16, width of the offset DAC control word
SETTLE_CYC, 1, wait cycles after each DAC trial before Q is sampled (at least 1)
SEL_W, 5, width of comparator index (log2 N_CMP)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a full calibration pass
cmp_mask  in  N_CMP  1 = calibrate comparator i; sampled on the accepted start
Q  in  N_CMP  comparator outputs, synchronous to clk
dac_ctl  out  DAC_BITS  offset DAC control word (registered)
cmp_sel  out  SEL_W  index of the comparator under calibration (registered)
res_we  out  1  one-cycle write strobe to the trim store
res_addr  out  SEL_W  write address, equal to cmp_sel
res_data  out  DAC_BITS  converged code
res_sat  out  1  qualifies res_we; 1 if the code is all-zeros or all-ones
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass
sat_cnt  out  SEL_W+1  number of saturated results in the last pass

Behaviour:
- Reset is synchronous and active-high: while rst=1 at a rising edge, the state goes to IDLE and all outputs clear to 0, including dac_ctl, cmp_sel, res_*, busy, done and sat_cnt.
- Reset mid-pass aborts immediately. No res_we is issued and no done pulse is produced.
- States: IDLE, SCAN, CLEAR, TRIAL, WAIT, STORE, FIN.
- IDLE: start=1 latches cmp_mask, sets cmp_sel=0, clears sat_cnt, sets busy=1 and goes to SCAN.
- start while busy=1 is ignored.
- SCAN (1 cycle): if mask[cmp_sel]=1, go to CLEAR.
- SCAN when mask[cmp_sel]=0: if cmp_sel is N_CMP-1, go to FIN; otherwise increment cmp_sel and stay in SCAN.
- CLEAR (1 cycle): dac_ctl<=0, bit index k<=DAC_BITS-1, go to TRIAL.
- TRIAL (1 cycle): dac_ctl[k]<=1, load the wait counter with SETTLE_CYC, go to WAIT.
- WAIT (SETTLE_CYC cycles): on the last cycle, sample Q[cmp_sel]. If it is 1, dac_ctl[k]<=0; if it is 0, the bit stays 1. Other bits are untouched.
- Leaving WAIT: if k=0, go to STORE; otherwise decrement k and go to TRIAL.
- Cycles per bit = 1+SETTLE_CYC.
- STORE (1 cycle): res_we=1, res_addr=cmp_sel, res_data=dac_ctl, res_sat=(dac_ctl==0 or all-ones). sat_cnt increments if res_sat.
- Leaving STORE: if cmp_sel is N_CMP-1, go to FIN; otherwise increment cmp_sel and go to SCAN. dac_ctl holds its value until the next CLEAR.
- FIN (1 cycle): done=1, busy<=0, dac_ctl<=0, cmp_sel<=0, return to IDLE.
- A start arriving in the FIN cycle is ignored. Start is accepted from IDLE only.
- res_we, res_sat and done are single-cycle pulses. res_addr and res_data are don't-care when res_we=0, but are driven 0 in that case.
- Latency per masked-in comparator = 1 (SCAN) + 1 (CLEAR) + DAC_BITS*(1+SETTLE_CYC) + 1 (STORE).
- At defaults that is 35 cycles per comparator.
- A full pass with all comparators masked in takes 32*35+1 = 1121 cycles from start to done.
- A masked-out comparator costs 1 SCAN cycle.
- An all-zero mask gives done exactly N_CMP+1 cycles after start, with no res_we.
- Q bits other than Q[cmp_sel] are ignored.
- Arithmetic: k is ceil(log2 DAC_BITS) bits wide and must not underflow. cmp_sel and sat_cnt never exceed their ranges.

Test Plan:
1. Model comparator 5 tripping when dac_ctl >= 0x5A3C, with all comparators masked in, SETTLE_CYC=1. Required: res_we with res_addr=5, res_data=0x5A3B, res_sat=0. done arrives 1121 cycles after start. sat_cnt=0.
2. Comparator 0 has Q stuck at 1 and comparator 31 has Q stuck at 0. Required: address 0 gets res_data=0x0000 and address 31 gets 0xFFFF, both with res_sat=1. sat_cnt=2.
3. cmp_mask=0x0000_0011. Required: exactly two res_we pulses, at addresses 0 then 4. The gap between the two STORE cycles is 35+3=38 cycles. done arrives 2*35+30 masked-out SCAN cycles+1 after start.
4. cmp_mask=0, start. Required: busy=1 for 33 cycles, done 33 cycles after start, no res_we, dac_ctl stays 0.
5. Assert rst during WAIT of comparator 7, bit 9. Required: on the next edge all outputs are 0 and the state is IDLE, with no res_we or done. A fresh start then completes a normal pass.
6. Pulse start again at cycles 10 and 500 of a pass, and also in the FIN cycle. Required: no restart, result sequence unchanged, exactly one done pulse.
